na4_match: RTL and testbench
============================

Name: na4_match

Overview:
- NA4 (naturally aligned 4-byte) address-match unit for the PMP checker.
- Decides whether an access starting at byte address addr and spanning size+1 bytes lies entirely inside the 4-byte region [addr_n, addr_n+3].
- The result is registered and feeds the PMP region-priority/permission logic.

Parameters:
- ADDR_W, 32, width of addr and addr_n in bits (unsigned).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  qualifies addr/addr_n/size for a new match request this cycle.
- addr  input  ADDR_W  access start byte address, unsigned.
- addr_n  input  ADDR_W  NA4 region base byte address (pmpaddr already shifted left by 2), unsigned.
- size  input  2  access extent minus one: last byte = addr+size (0..3).
- na4_out  output  1  registered match result: 1 = access fully inside region.
- valid_out  output  1  registered copy of valid_in; marks na4_out as fresh.

Behaviour:
- Arithmetic is unsigned and ADDR_W+1 bits wide, so there is no silent wrap.
  - end_a = {0,addr} + size.
  - end_r = {0,addr_n} + 3.
- Combinational match term m:
  - m = (addr >= addr_n) AND (end_a <= end_r) AND (end_a[ADDR_W] == 0).
  - The last term is the overflow guard: an access whose last byte wraps past 2^ADDR_W-1 never matches.
  - A region whose end_r exceeds 2^ADDR_W-1 still matches non-overflowing accesses that satisfy the first two terms.
- Region base alignment is not checked: addr_n is used as given, and the region is exactly addr_n..addr_n+3.
- Registering, on rising clk:
  - if rst: na4_out <= 0, valid_out <= 0.
  - else: valid_out <= valid_in.
  - na4_out <= m when valid_in = 1; otherwise na4_out <= 0.
- Latency: exactly 1 cycle from inputs to na4_out/valid_out. Back-to-back requests are accepted every cycle, with no stall or handshake back-pressure.
- Reset mid-operation: a request presented in the same cycle rst is high is discarded, giving na4_out = 0 and valid_out = 0 the next cycle.
- No internal state other than the two output flops; no X propagation. Inputs are sampled only at the clock edge.

Boundary conditions (all with valid_in = 1):
- Exact single-byte hit at the base: addr = addr_n, size = 0 -> 1.
- Full region: addr = addr_n, size = 3 -> 1.
- Last byte one past the region, addr+size = addr_n+4 -> 0.
- Start below the base, addr = addr_n-1 -> 0, for any size.
- addr = 2^ADDR_W-1 with size >= 1 -> 0, for any addr_n (overflow guard).
- addr = 2^ADDR_W-1 with size = 0 and addr_n = 2^ADDR_W-1 -> 1.

Test Plan:
- Overflow: addr=0xFFFFFFFF, addr_n=0x00000000, size=2, valid_in=1 -> next cycle na4_out=0, valid_out=1.
- Exact hit and full span, each presented in its own cycle:
  - addr=100, addr_n=100, size=0 -> na4_out=1.
  - addr=50, addr_n=50, size=3 -> na4_out=1.
- Range violations, each presented in its own cycle:
  - Exceeds end: addr=103, addr_n=100, size=1 -> na4_out=0.
  - Below base: addr=99, addr_n=100, size=0 -> na4_out=0.
- Boundary fit: addr=101, addr_n=100, size=2 -> na4_out=1. Then apply the same inputs with valid_in=0 -> next cycle na4_out=0, valid_out=0.
- Pipelining: drive the six cases above on consecutive cycles with valid_in=1 -> results appear in the same order, each one cycle later, with no bubbles.
- Reset: assert rst for one cycle while driving addr=100, addr_n=100, size=0, valid_in=1 -> na4_out=0 and valid_out=0 after that edge. Normal results resume on the first cycle after rst deasserts.

Source files
------------

// File: rtl/na4_match_if.sv
// Request/response bundle for the NA4 address-match unit.
// The requester (PMP checker) drives the access and region base,
// and receives the registered match result one cycle later.
interface na4_match_if #(
  parameter int ADDR_W = 32
);
  logic              valid_in;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_n;
  logic [1:0]        size;
  logic              na4_out;
  logic              valid_out;

  modport master (
    output valid_in,
    output addr,
    output addr_n,
    output size,
    input  na4_out,
    input  valid_out
  );

  modport slave (
    input  valid_in,
    input  addr,
    input  addr_n,
    input  size,
    output na4_out,
    output valid_out
  );
endinterface

// File: rtl/na4_match.sv
// NA4 (naturally aligned 4-byte) address-match unit for the PMP checker.
// Reports, one cycle after a request, whether the access addr..addr+size
// lies entirely within the 4-byte region addr_n..addr_n+3. All end-of-range
// arithmetic is carried one bit wider than the address so that an access
// wrapping past the top of the address space is seen and rejected instead
// of aliasing to a low address.
module na4_match #(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  na4_match_if.slave bus
);

  logic [ADDR_W:0] end_a;
  logic [ADDR_W:0] end_r;
  logic            m;

  // Compute the widened end addresses and the combinational match term.
  always_comb begin
    end_a = {1'b0, bus.addr}   + {{(ADDR_W-1){1'b0}}, bus.size};
    end_r = {1'b0, bus.addr_n} + {{(ADDR_W-1){1'b0}}, 2'b11};
    m     = (bus.addr >= bus.addr_n) && (end_a <= end_r) && !end_a[ADDR_W];
  end

  // Register the result; an unqualified or reset cycle always yields no match.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.na4_out   <= 1'b0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.valid_out <= bus.valid_in;
      bus.na4_out   <= bus.valid_in ? m : 1'b0;
    end
  end

endmodule

// File: tb/tb_na4_match.sv
// Scoreboard bench for na4_match: every driven cycle pushes its hand-computed
// expected {valid_out, na4_out}; a monitor pops and compares one cycle later.
module tb_na4_match;

  localparam int ADDR_W = 32;

  typedef struct {
    logic       exp_valid;
    logic       exp_na4;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  int   check_count;
  int   pass_count;
  bit   stim_done;
  exp_t exp_q[$];

  na4_match_if #(.ADDR_W(ADDR_W)) bus ();

  na4_match #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs at the falling edge and queue its expected result.
  task automatic applyStimulus(input logic r, input logic v,
                               input logic [ADDR_W-1:0] a,
                               input logic [ADDR_W-1:0] an,
                               input logic [1:0] s,
                               input logic exp_na4,
                               input string name);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.valid_in = v;
    bus.addr     = a;
    bus.addr_n   = an;
    bus.size     = s;
    e.exp_valid  = v & ~r;
    e.exp_na4    = exp_na4;
    e.name       = name;
    exp_q.push_back(e);
  endtask

  // Compare registered outputs against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    check_count++;
    if (bus.valid_out === e.exp_valid && bus.na4_out === e.exp_na4) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got valid_out=%b na4_out=%b, expected valid_out=%b na4_out=%b",
               e.name, bus.valid_out, bus.na4_out, e.exp_valid, e.exp_na4);
    end
  endtask

  // Monitor: just after each rising edge, the oldest queued request is at the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Apply the six core cases back to back.
  task automatic coreCases(input string tag);
    applyStimulus(0, 1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd2, 1'b0, {tag, "_overflow"});
    applyStimulus(0, 1, 32'd100,       32'd100,       2'd0, 1'b1, {tag, "_exact_hit"});
    applyStimulus(0, 1, 32'd50,        32'd50,        2'd3, 1'b1, {tag, "_full_span"});
    applyStimulus(0, 1, 32'd103,       32'd100,       2'd1, 1'b0, {tag, "_exceeds_end"});
    applyStimulus(0, 1, 32'd99,        32'd100,       2'd0, 1'b0, {tag, "_below_base"});
    applyStimulus(0, 1, 32'd101,       32'd100,       2'd2, 1'b1, {tag, "_boundary_fit"});
  endtask

  // Directed stimulus sequence.
  initial begin
    check_count  = 0;
    pass_count   = 0;
    stim_done    = 1'b0;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.addr     = '0;
    bus.addr_n   = '0;
    bus.size     = '0;

    // Reset state, with a live request that must be discarded.
    applyStimulus(1, 1, 32'd100, 32'd100, 2'd0, 1'b0, "reset_state");
    applyStimulus(1, 0, 32'd0,   32'd0,   2'd0, 1'b0, "reset_hold");

    // Individual cases, each separated by an idle cycle.
    applyStimulus(0, 1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd2, 1'b0, "overflow");
    applyStimulus(0, 0, 32'd0, 32'd0, 2'd0, 1'b0, "idle0");
    applyStimulus(0, 1, 32'd100, 32'd100, 2'd0, 1'b1, "exact_hit");
    applyStimulus(0, 0, 32'd0, 32'd0, 2'd0, 1'b0, "idle1");
    applyStimulus(0, 1, 32'd50, 32'd50, 2'd3, 1'b1, "full_span");
    applyStimulus(0, 0, 32'd0, 32'd0, 2'd0, 1'b0, "idle2");
    applyStimulus(0, 1, 32'd103, 32'd100, 2'd1, 1'b0, "exceeds_end");
    applyStimulus(0, 0, 32'd0, 32'd0, 2'd0, 1'b0, "idle3");
    applyStimulus(0, 1, 32'd99, 32'd100, 2'd0, 1'b0, "below_base");
    applyStimulus(0, 0, 32'd0, 32'd0, 2'd0, 1'b0, "idle4");
    applyStimulus(0, 1, 32'd101, 32'd100, 2'd2, 1'b1, "boundary_fit");
    applyStimulus(0, 0, 32'd101, 32'd100, 2'd2, 1'b0, "boundary_fit_invalid");

    // Further boundaries.
    applyStimulus(0, 1, 32'd102, 32'd100, 2'd2, 1'b0, "one_past_end");
    applyStimulus(0, 1, 32'd99,  32'd100, 2'd3, 1'b0, "below_base_size3");
    applyStimulus(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b1, "top_byte_hit");
    applyStimulus(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 2'd1, 1'b0, "top_wrap_guard");
    applyStimulus(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'd0, 1'b1, "region_past_top");
    applyStimulus(0, 1, 32'd104, 32'd101, 2'd0, 1'b1, "unaligned_base_hit");
    applyStimulus(0, 1, 32'd104, 32'd101, 2'd1, 1'b0, "unaligned_base_miss");

    // Pipelining: the six core cases on consecutive cycles.
    coreCases("pipe");

    // Mid-operation reset, then normal results resume.
    applyStimulus(1, 1, 32'd100, 32'd100, 2'd0, 1'b0, "mid_reset");
    applyStimulus(0, 1, 32'd100, 32'd100, 2'd0, 1'b1, "after_reset_hit");
    applyStimulus(0, 1, 32'd103, 32'd100, 2'd1, 1'b0, "after_reset_miss");
    applyStimulus(0, 0, 32'd0, 32'd0, 2'd0, 1'b0, "final_idle");
    stim_done = 1'b1;
  end

  // Wait for the scoreboard to drain (bounded), then report.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      check_count++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
